// File: rtl/calc_trace.sv
// calc_trace: watches the CPU observation buses, logs every change of architectural
// state into an entry FIFO and streams entries out as four 32-bit words.
module calc_trace #(
   parameter int DEPTH       = 8,
   parameter int HALT_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Enable,
   input  logic [31:0]            InstrAtual,
   input  logic [31:0]            RegA,
   input  logic [31:0]            RegB,
   input  logic [31:0]            RAcc,
   output logic [31:0]            TraceData,
   output logic                   TraceValid,
   input  logic                   TraceReady,
   output logic                   TraceLast,
   output logic                   Halted,
   output logic                   Overflow,
   output logic [CNT_W-1:0]       DropCount,
   output logic [$clog2(DEPTH):0] EntryCount
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [SW-1:0] HALT_CNT = SW'(HALT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [127:0]     snap;
   logic [127:0]     prev_q;
   logic             prev_vld_q, prev_vld_d;
   logic [SW-1:0]    stable_q, stable_d;
   logic             capture, push;

   logic [127:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [1:0]       widx_q, widx_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             xfer, pop, full, accept, drop;
   logic [127:0]     head;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign snap    = {InstrAtual, RegA, RegB, RAcc};
   assign capture = Enable && (state_q != S_HALT);

   always_comb begin
      state_d    = state_q;
      prev_vld_d = prev_vld_q;
      stable_d   = stable_q;
      push       = 1'b0;
      if (state_q != S_HALT) begin
         if (!Enable) begin
            state_d    = S_IDLE;
            prev_vld_d = 1'b0;
            stable_d   = '0;
         end else begin
            state_d    = S_RUN;
            prev_vld_d = 1'b1;
            if (!prev_vld_q || (snap != prev_q)) begin
               push     = 1'b1;
               stable_d = '0;
            end else begin
               // Counter stops at HALT_CNT because HALTED never re-enters this path.
               stable_d = stable_q + SW'(1);
               if (stable_d == HALT_CNT) state_d = S_HALT;
            end
         end
      end
   end

   assign TraceValid = (cnt_q != '0);
   assign xfer       = TraceValid && TraceReady;
   assign pop        = xfer && (widx_q == 2'd3);
   assign full       = (cnt_q == FULL_CNT);
   assign accept     = push && (!full || pop);
   assign drop       = push && full && !pop;
   assign head       = mem_q[rd_q];

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      widx_d = widx_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (xfer)   widx_d = widx_q + 2'd1;
      if (pop)    rd_d   = rd_q + AW'(1);
      if (accept) wr_d   = wr_q + AW'(1);
      if (accept && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!accept && pop) cnt_d = cnt_q - (AW+1)'(1);
      if (drop) begin
         ovf_d  = 1'b1;
         drop_d = sat_inc(drop_q);
      end
   end

   always_comb begin
      TraceData = '0;
      if (TraceValid) begin
         case (widx_q)
            2'd0:    TraceData = head[127:96];
            2'd1:    TraceData = head[95:64];
            2'd2:    TraceData = head[63:32];
            default: TraceData = head[31:0];
         endcase
      end
   end

   assign TraceLast  = TraceValid && (widx_q == 2'd3);
   assign Halted     = (state_q == S_HALT);
   assign Overflow   = ovf_q;
   assign DropCount  = drop_q;
   assign EntryCount = cnt_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         prev_vld_q <= 1'b0;
         stable_q   <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         widx_q     <= '0;
         ovf_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         prev_vld_q <= prev_vld_d;
         stable_q   <= stable_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         widx_q     <= widx_d;
         ovf_q      <= ovf_d;
         drop_q     <= drop_d;
      end
   end

   // Snapshot and FIFO storage carry no reset; their valid flags and pointers do.
   always_ff @(posedge Clk) begin
      if (capture) prev_q <= snap;
      if (accept)  mem_q[wr_q] <= snap;
   end

endmodule

// File: doc/calc_trace.md
Name: calc_trace

Overview:
- Downstream observer of the accumulator CPU top. Consumes its four observation buses (RegA, RegB, RAcc, InstrAtual) every Clk.
- Logs each change of architectural state into an entry FIFO and streams the entries out as 32-bit words over a valid/ready interface.
- Detects CPU halt (state frozen) and stops capturing. Used by benches and the board debug port.

Parameters:
- DEPTH, 8, FIFO depth in entries; power of two, ≥2.
- HALT_CYCLES, 4, consecutive identical samples (after the last change) that declare halt; ≥1.
- CNT_W, 16, width of DropCount.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Enable  in  1  level; starts capture from IDLE.
- InstrAtual  in  32  current instruction from CPU.
- RegA  in  32  register A from CPU.
- RegB  in  32  register B from CPU.
- RAcc  in  32  accumulator from CPU.
- TraceData  out  32  current output word.
- TraceValid  out  1  TraceData valid.
- TraceReady  in  1  consumer accepts word.
- TraceLast  out  1  high on word 3 of an entry.
- Halted  out  1  halt detected, sticky until Reset.
- Overflow  out  1  sticky; an entry was dropped.
- DropCount  out  CNT_W  dropped entries, saturating.
- EntryCount  out  log2(DEPTH)+1  entries held in the FIFO.

Behaviour:
- Reset: all outputs 0. TraceData = 0; state = IDLE; FIFO empty; word index 0; stable counter 0; previous snapshot invalid.
- Snapshot = {InstrAtual, RegA, RegB, RAcc}, sampled at each rising Clk.
- States:
  - IDLE -> RUN when Enable = 1 at an edge. That edge's sample is the first capture.
  - RUN -> HALTED when the stable counter reaches HALT_CYCLES.
  - RUN -> IDLE when Enable = 0 at an edge. In this case the snapshot valid flag clears and the stable counter clears.
  - HALTED: terminal until Reset. No pushes; the FIFO still drains.
- Capture in RUN:
  - Push when the previous snapshot is invalid or the snapshot differs from the previous one. On a push, the stable counter resets to 0.
  - An identical snapshot is not pushed; the stable counter increments.
  - The previous snapshot register updates every RUN edge.
- Entry layout out of the FIFO, word order 0..3: InstrAtual, RegA, RegB, RAcc. TraceLast = 1 on word 3 only.
- Output handshake:
  - TraceValid = 1 whenever the FIFO is non-empty. TraceData is the head entry word selected by the word index.
  - A word transfers when TraceValid & TraceReady at an edge; the word index then increments.
  - Transfer of word 3 pops the entry and the index wraps to 0.
  - TraceData and TraceLast are stable while TraceValid & !TraceReady.
- Latency: an entry pushed at edge N gives TraceValid = 1 after edge N (registered FIFO storage, combinational read of head). The minimum drain is 4 cycles per entry.
- Full:
  - A push while full with no same-edge pop of word 3: entry dropped, Overflow <= 1, DropCount += 1, saturating at all-ones.
  - A push while full with a same-edge pop of word 3: accepted; EntryCount unchanged.
- Simultaneous push and pop when not full: EntryCount unchanged. Pointers wrap modulo DEPTH.
- Halted asserts on the edge where the stable counter reaches HALT_CYCLES. The counter saturates there.
- Reset mid-transfer: the partially sent entry and all queued entries are discarded. The next Reset-free edge starts from IDLE.
- Reset has priority over Enable, pushes and pops on the same edge.
- Suppression is intentional: consecutive identical instructions that leave registers unchanged produce one entry.

Test Plan:
- Reset, Enable = 1, constant snapshot {0x20000005, 0, 0, 0}, TraceReady = 0 -> one entry; EntryCount = 1. Halted = 1 exactly 4 edges after the capture edge. No further entries.
- Snapshots change every cycle for 3 cycles (RAcc = 1, 2, 3), TraceReady = 1 -> 12 words in order. TraceLast high on words 4, 8 and 12. RAcc words read 1, 2, 3.
- TraceReady = 0; 10 distinct snapshots, DEPTH = 8 -> EntryCount = 8, Overflow = 1, DropCount = 2. The drain returns the first 8 entries in order.
- FIFO full; TraceReady held high so word 3 transfers on the same edge as a new distinct snapshot -> entry accepted, Overflow stays 0, EntryCount stays 8.
- TraceReady toggled 1,0,1,0 during an entry -> TraceData is held stable while stalled. Words arrive with no loss or duplication.
- Reset pulsed after word 1 of an entry is transferred, with 3 entries queued -> next cycle TraceValid = 0, EntryCount = 0, Halted = 0, state IDLE.
